// File: rtl/my_serial_pkg.sv
// Shared types and defaults for the serial UART: FSM state encodings,
// frame geometry and parameter defaults.
package my_serial_pkg;

    localparam int FRAME_BITS           = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/my_sync_fifo.sv
// Show-ahead synchronous FIFO; flags decode only from the registered occupancy.
// A pop on a full FIFO frees the slot for a same-cycle push.
module my_sync_fifo
    import my_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == CNT_FULL);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/my_serial_uart.sv
// 8N1 UART with TX and RX FIFOs facing the data memory serial port.
// TX line and all status pulses are registered.
module my_serial_uart
    import my_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data_in,
    input  logic       tx_wren_in,
    output logic       tx_ready_out,
    input  logic       rx_rden_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out,
    input  logic       uart_rxd_in,
    output logic       uart_txd_out
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(FRAME_BITS - 1);

    tx_state_t   tx_state_r;
    logic [15:0] tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_txd_r;
    logic [7:0]  tx_head_s;
    logic        tx_empty_s;
    logic        tx_full_s;
    logic        tx_pop_s;
    logic        tx_bit_end_s;

    rx_state_t   rx_state_r;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic [1:0]  rx_sync_r;
    logic        rx_last_r;
    logic        rx_overrun_r;
    logic        rx_frame_err_r;
    logic        rx_bit_s;
    logic        rx_bit_end_s;
    logic        rx_push_s;
    logic        rx_empty_s;
    logic        rx_full_s;

    my_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_wren_in),
        .push_data (tx_data_in),
        .pop       (tx_pop_s),
        .head_data (tx_head_s),
        .empty     (tx_empty_s),
        .full      (tx_full_s)
    );

    my_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push_s),
        .push_data (rx_shift_r),
        .pop       (rx_rden_in),
        .head_data (rx_data_out),
        .empty     (rx_empty_s),
        .full      (rx_full_s)
    );

    assign tx_ready_out     = !tx_full_s;
    assign rx_valid_out     = !rx_empty_s;
    assign uart_txd_out     = tx_txd_r;
    assign rx_overrun_out   = rx_overrun_r;
    assign rx_frame_err_out = rx_frame_err_r;

    assign tx_bit_end_s = (tx_cnt_r == BIT_LAST);
    // Popping at the end of STOP is what makes back-to-back frames gapless.
    assign tx_pop_s     = !tx_empty_s &&
                          ((tx_state_r == TX_IDLE) || ((tx_state_r == TX_STOP) && tx_bit_end_s));

    // Transmit FSM: shifts the popped byte out LSB first behind a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_txd_r   <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= 16'd0;
                    if (tx_pop_s) begin
                        tx_shift_r <= tx_head_s;
                        tx_txd_r   <= 1'b0;
                        tx_state_r <= TX_START;
                    end else begin
                        tx_txd_r   <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_r   <= 16'd0;
                        tx_bit_r   <= 3'd0;
                        tx_txd_r   <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r   <= tx_cnt_r + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_r <= 16'd0;
                        if (tx_bit_r == LAST_BIT) begin
                            tx_txd_r   <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_txd_r   <= tx_shift_r[1];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_r <= 16'd0;
                        if (tx_pop_s) begin
                            tx_shift_r <= tx_head_s;
                            tx_txd_r   <= 1'b0;
                            tx_state_r <= TX_START;
                        end else begin
                            tx_state_r <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_cnt_r   <= 16'd0;
                    tx_txd_r   <= 1'b1;
                end
            endcase
        end
    end

    assign rx_bit_s     = rx_sync_r[1];
    assign rx_bit_end_s = (rx_cnt_r == BIT_LAST);
    assign rx_push_s    = (rx_state_r == RX_STOP) && rx_bit_end_s && rx_bit_s;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_r <= 2'b11;
            rx_last_r <= 1'b1;
        end else begin
            rx_sync_r <= {rx_sync_r[0], uart_rxd_in};
            rx_last_r <= rx_sync_r[1];
        end
    end

    // Receive FSM: half-bit start check, then mid-bit sampling of data and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r     <= RX_IDLE;
            rx_cnt_r       <= 16'd0;
            rx_bit_r       <= 3'd0;
            rx_shift_r     <= 8'd0;
            rx_overrun_r   <= 1'b0;
            rx_frame_err_r <= 1'b0;
        end else begin
            rx_overrun_r   <= 1'b0;
            rx_frame_err_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= 16'd0;
                    if (rx_last_r && !rx_bit_s) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= 16'd0;
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_bit_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r   <= rx_cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end_s) begin
                        rx_cnt_r   <= 16'd0;
                        rx_shift_r <= {rx_bit_s, rx_shift_r[7:1]};
                        if (rx_bit_r == LAST_BIT) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r   <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end_s) begin
                        rx_cnt_r   <= 16'd0;
                        rx_state_r <= RX_IDLE;
                        if (rx_bit_s) begin
                            rx_overrun_r   <= rx_full_s && !rx_rden_in;
                        end else begin
                            rx_frame_err_r <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/my_serial_uart.md
MY_SERIAL_UART -- requirements
Module: my_serial_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, entries per FIFO; power of two, 2..256.
REQ-003 clock  input  1  single clock domain; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data_in  input  8  byte to transmit; driven by data memory serial_out.
REQ-006 tx_wren_in  input  1  write strobe; driven by data memory serial_wren_out.
REQ-007 tx_ready_out  output  1  TX FIFO not full; feeds data memory serial_ready_in.
REQ-008 rx_rden_in  input  1  pop strobe; driven by data memory serial_rden_out.
REQ-009 rx_data_out  output  8  RX FIFO head byte; feeds data memory serial_in.
REQ-010 rx_valid_out  output  1  RX FIFO not empty; feeds data memory serial_valid_in.
REQ-011 rx_overrun_out  output  1  one-cycle pulse when a received byte is dropped because the RX FIFO is full.
REQ-012 rx_frame_err_out  output  1  one-cycle pulse when a received stop bit samples 0.
REQ-013 uart_rxd_in  input  1  asynchronous serial line in; idle high.
REQ-014 uart_txd_out  output  1  serial line out, registered; idle high.

Function
REQ-015 Frame format SHALL be 8N1: start 0, eight data bits LSB first, stop 1; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 A TX write SHALL be accepted on an edge where tx_wren_in=1 and tx_ready_out=1; a write while full SHALL be dropped silently.
REQ-017 tx_ready_out and rx_valid_out SHALL be decoded from registered FIFO occupancy only, with no combinational path from any input.
REQ-018 TX FSM states: IDLE, START, DATA, STOP; IDLE->START pops the FIFO when it is non-empty; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bits; STOP->START when the FIFO is non-empty at stop end, else ->IDLE.
REQ-019 A byte written at edge k into an empty TX FIFO with TX idle SHALL drive uart_txd_out low from edge k+1.
REQ-020 Back-to-back TX frames SHALL have no idle gap between the stop bit and the next start bit.
REQ-021 uart_rxd_in SHALL pass a 2-flop synchronizer; both flops reset to 1.
REQ-022 RX FSM states: IDLE, START, DATA, STOP; a synchronized falling edge moves IDLE->START.
REQ-023 START SHALL re-sample after CLKS_PER_BIT/2 cycles: if 0, go to DATA; if 1, treat as a glitch and return to IDLE.
REQ-024 DATA SHALL sample each bit at its mid-point (every CLKS_PER_BIT cycles) into a shift register, LSB first.
REQ-025 At STOP mid-point: a 1 pushes the byte; a 0 discards the byte and pulses rx_frame_err_out; RX then returns to IDLE.
REQ-026 rx_valid_out SHALL assert on the cycle after the edge that samples the stop bit.
REQ-027 An RX push into a full FIFO SHALL drop the new byte, pulse rx_overrun_out and keep the FIFO contents.
REQ-028 RX FIFO SHALL be show-ahead; rx_rden_in pops when rx_valid_out=1 and SHALL be ignored when empty.
REQ-029 Simultaneous push and pop on a full FIFO SHALL both succeed with occupancy unchanged; on an empty FIFO only the push takes effect.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.

Reset
REQ-031 On reset low: both FSMs to IDLE, FIFOs empty, counters 0, uart_txd_out=1, tx_ready_out=1, rx_valid_out=0, rx_data_out=0, rx_overrun_out=0, rx_frame_err_out=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately; the partial RX byte is lost and TX idles high.

Structure
REQ-033 Package my_serial_pkg SHALL hold the TX and RX state enum typedefs, the frame bit-count constant (8) and the default parameter values.
REQ-034 Both FIFOs SHALL be instances of one sub-module, my_sync_fifo, parameterized by width (8) and depth.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-035 Write 0xA5 at idle -> txd low the next cycle, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then stop high; 80 cycles total.
REQ-036 Write 5 bytes back-to-back -> first 5 accepted (one in flight plus 4 queued), tx_ready_out=0 when full, frames contiguous with no idle gap.
REQ-037 Drive frame 0x3C on rxd -> rx_valid_out=1 with rx_data_out=0x3C; rx_rden_in pulse -> rx_valid_out=0.
REQ-038 Receive 5 frames with no pops -> 4 stored, rx_overrun_out pulses once, pops return them in order.
REQ-039 Frame with stop bit 0 -> rx_frame_err_out pulses, rx_valid_out stays 0; 2-cycle low glitch -> no activity.
REQ-040 Assert reset mid TX frame -> uart_txd_out=1 immediately and all outputs at reset values.
